// File: rtl/gray_codec_pipe.sv
// Pipelined Gray<->binary converter, direction chosen per beat; latency STAGES cycles.
// Ready chain stalls any stage without bubbles. GC_SEQ_CHECK_EN adds a Gray adjacency checker.
module gray_codec_pipe #(
    parameter int DATA_WIDTH = 16,
    parameter int STAGES     = 2
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_mode,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_mode,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  seq_err
);

    localparam int W = DATA_WIDTH;
    localparam int S = STAGES;
    localparam int C = (W + S - 1) / S;

    // Stage k finishes its chunk of the MSB-down prefix XOR; bits above the chunk
    // are already binary, bits below still travel as raw Gray.
    function automatic logic [W-1:0] stage_fn(input logic [W-1:0] d, input logic m, input int k);
        logic [W-1:0] r;
        r = d;
        if (m) begin
            if (k == 0) r = d ^ (d >> 1);
        end else begin
            for (int i = W - 2; i >= 0; i--) begin
                if (i <= W - 1 - k * C && i >= W - (k + 1) * C) r[i] = r[i] ^ r[i+1];
            end
        end
        return r;
    endfunction

    logic [S-1:0] vld_q, mode_q, adv, nvld, nmode;
    logic [W-1:0] data_q [S];
    logic [W-1:0] ndat   [S];

    always_comb begin
        logic carry;
        carry = out_ready;
        adv   = '0;
        nvld  = '0;
        nmode = '0;
        for (int k = 0; k < S; k++) ndat[k] = '0;
        for (int k = S - 1; k >= 0; k--) begin
            carry  = carry | ~vld_q[k];
            adv[k] = carry;
        end
        nvld[0]  = in_valid;
        nmode[0] = in_mode;
        ndat[0]  = stage_fn(in_data, in_mode, 0);
        for (int k = 1; k < S; k++) begin
            nvld[k]  = vld_q[k-1];
            nmode[k] = mode_q[k-1];
            ndat[k]  = stage_fn(data_q[k-1], mode_q[k-1], k);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vld_q  <= '0;
            mode_q <= '0;
            for (int k = 0; k < S; k++) data_q[k] <= '0;
        end else begin
            for (int k = 0; k < S; k++) begin
                if (adv[k]) begin
                    vld_q[k] <= nvld[k];
                    if (nvld[k]) begin
                        mode_q[k] <= nmode[k];
                        data_q[k] <= ndat[k];
                    end
                end
            end
        end
    end

    assign in_ready  = adv[0];
    assign out_valid = vld_q[S-1];
    assign out_mode  = mode_q[S-1];
    assign out_data  = data_q[S-1];

`ifdef GC_SEQ_CHECK_EN
    logic [W-1:0] prev_gray;
    logic         prev_ok;
    logic         err_in;
    logic [S-1:0] err_q, nerr;

    always_comb begin
        err_in  = !in_mode && prev_ok && ($countones(in_data ^ prev_gray) != 1);
        nerr    = '0;
        nerr[0] = err_in;
        for (int k = 1; k < S; k++) nerr[k] = err_q[k-1];
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            prev_gray <= '0;
            prev_ok   <= 1'b0;
            err_q     <= '0;
        end else begin
            if (in_valid && adv[0] && !in_mode) begin
                prev_gray <= in_data;
                prev_ok   <= 1'b1;
            end
            for (int k = 0; k < S; k++) begin
                if (adv[k] && nvld[k]) err_q[k] <= nerr[k];
            end
        end
    end

    assign seq_err = vld_q[S-1] && err_q[S-1];
`else
    assign seq_err = 1'b0;
`endif

endmodule

// File: tb/tb_gray_codec_pipe.sv
module tb_gray_codec_pipe;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

`ifdef GC_SEQ_CHECK_EN
    localparam bit SEQ_EN = 1'b1;
`else
    localparam bit SEQ_EN = 1'b0;
`endif

    logic        v4, m4, r4, rdy4, ov4, om4, se4;
    logic [3:0]  d4, od4;
    logic        v16, m16, r16, rdy16, ov16, om16, se16;
    logic [15:0] d16, od16;

    gray_codec_pipe #(.DATA_WIDTH(4), .STAGES(2)) u4 (
        .clk(clk), .resetn(resetn), .in_valid(v4), .in_ready(rdy4), .in_mode(m4),
        .in_data(d4), .out_valid(ov4), .out_ready(r4), .out_mode(om4), .out_data(od4),
        .seq_err(se4));

    gray_codec_pipe #(.DATA_WIDTH(16), .STAGES(4)) u16 (
        .clk(clk), .resetn(resetn), .in_valid(v16), .in_ready(rdy16), .in_mode(m16),
        .in_data(d16), .out_valid(ov16), .out_ready(r16), .out_mode(om16), .out_data(od16),
        .seq_err(se16));

    typedef struct packed {
        logic        mode;
        logic [15:0] data;
        logic        serr;
    } exp_t;

    exp_t        q4[$];
    exp_t        q16[$];
    int          nvec = 0;
    int          nerr = 0;
    int          cyc = 0;
    logic [15:0] pg4, pg16;
    logic        pok4, pok16, acc4, acc16, rnd16, hold16;
    logic [16:0] held16;
    logic [3:0]  serr_hist;

    function automatic logic [15:0] g2b(input logic [15:0] g);
        logic [15:0] b;
        b[15] = g[15];
        for (int i = 14; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    function automatic logic [15:0] model(input logic m, input logic [15:0] d);
        return m ? (d ^ (d >> 1)) : g2b(d);
    endfunction

    function automatic logic seq_model(input logic m, input logic [15:0] d,
                                       input logic [15:0] pg, input logic ok);
        return SEQ_EN && !m && ok && ($countones(d ^ pg) != 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp)
        else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: called just after a negedge with inputs already driven.
    task automatic tick();
        exp_t e;
        if (rnd16) r16 = 1'($urandom_range(0, 1));
        #1;
        acc4  = v4 && rdy4;
        acc16 = v16 && rdy16;
        if (acc4) begin
            e.mode = m4;
            e.data = model(m4, {12'b0, d4});
            e.serr = seq_model(m4, {12'b0, d4}, pg4, pok4);
            q4.push_back(e);
            if (!m4) begin pg4 = {12'b0, d4}; pok4 = 1'b1; end
        end
        if (acc16) begin
            e.mode = m16;
            e.data = model(m16, d16);
            e.serr = seq_model(m16, d16, pg16, pok16);
            q16.push_back(e);
            if (!m16) begin pg16 = d16; pok16 = 1'b1; end
        end
        if (ov4 && r4) begin
            chk("dut4_beat_expected", 32'(q4.size() > 0), 32'd1);
            if (q4.size() > 0) begin
                e = q4.pop_front();
                chk("dut4_data", 32'(od4), 32'(e.data));
                chk("dut4_mode", 32'(om4), 32'(e.mode));
                chk("dut4_seq_err", 32'(se4), 32'(e.serr));
                serr_hist = {serr_hist[2:0], se4};
            end
        end
        if (hold16) begin
            chk("dut16_hold_valid", 32'(ov16), 32'd1);
            chk("dut16_hold_data", 32'({om16, od16}), 32'(held16));
        end
        hold16 = ov16 && !r16;
        held16 = {om16, od16};
        if (ov16 && r16) begin
            chk("dut16_beat_expected", 32'(q16.size() > 0), 32'd1);
            if (q16.size() > 0) begin
                e = q16.pop_front();
                chk("dut16_data", 32'(od16), 32'(e.data));
                chk("dut16_mode", 32'(om16), 32'(e.mode));
                chk("dut16_seq_err", 32'(se16), 32'(e.serr));
            end
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic send4(input logic m, input logic [3:0] d);
        v4 = 1'b1; m4 = m; d4 = d;
        for (int n = 0; n < 100; n++) begin
            tick();
            if (acc4) break;
        end
        chk("dut4_accept", 32'(acc4), 32'd1);
    endtask

    task automatic send16(input logic m, input logic [15:0] d);
        v16 = 1'b1; m16 = m; d16 = d;
        for (int n = 0; n < 100; n++) begin
            tick();
            if (acc16) break;
        end
        chk("dut16_accept", 32'(acc16), 32'd1);
    endtask

    task automatic drain4();
        v4 = 1'b0;
        for (int n = 0; n < 100 && q4.size() > 0; n++) tick();
        chk("dut4_drain", 32'(q4.size()), 32'd0);
    endtask

    task automatic drain16();
        v16 = 1'b0;
        for (int n = 0; n < 2000 && q16.size() > 0; n++) tick();
        chk("dut16_drain", 32'(q16.size()), 32'd0);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        q4.delete(); q16.delete();
        pok4 = 1'b0; pok16 = 1'b0; hold16 = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
    endtask

    initial begin
        int cyc0;
        v4 = 0; m4 = 0; d4 = '0; r4 = 1;
        v16 = 0; m16 = 0; d16 = '0; r16 = 1;
        rnd16 = 0; hold16 = 0; held16 = '0; pok4 = 0; pok16 = 0;
        pg4 = '0; pg16 = '0; serr_hist = '0; acc4 = 0; acc16 = 0;

        // Reset state
        @(negedge clk);
        chk("rst_out_valid", 32'(ov4), 32'd0);
        chk("rst_out_data", 32'(od4), 32'd0);
        chk("rst_out_mode", 32'(om4), 32'd0);
        chk("rst_seq_err", 32'(se4), 32'd0);
        chk("rst_out_valid16", 32'(ov16), 32'd0);
        chk("rst_out_data16", 32'(od16), 32'd0);
        resetn = 1'b1;
        #1;
        chk("rst_in_ready", 32'(rdy4), 32'd1);
        chk("rst_in_ready16", 32'(rdy16), 32'd1);
        @(negedge clk);

        // T1: Gray 1101 -> binary 1001, exactly 2 cycles of latency
        v4 = 1; m4 = 0; d4 = 4'b1101;
        tick();
        chk("t1_accept", 32'(acc4), 32'd1);
        v4 = 0;
        chk("t1_not_early", 32'(ov4), 32'd0);
        tick();
        chk("t1_valid", 32'(ov4), 32'd1);
        chk("t1_data", 32'(od4), 32'b1001);
        chk("t1_mode", 32'(om4), 32'd0);
        tick();

        // T2: binary 1001 -> Gray 1101
        v4 = 1; m4 = 1; d4 = 4'b1001;
        tick();
        v4 = 0;
        tick();
        chk("t2_valid", 32'(ov4), 32'd1);
        chk("t2_data", 32'(od4), 32'b1101);
        chk("t2_mode", 32'(om4), 32'd1);
        tick();

        // T2 sweep: both modes back-to-back at one beat per cycle
        cyc0 = cyc;
        for (int i = 0; i < 16; i++) send4(1'b0, 4'(i));
        for (int i = 0; i < 16; i++) send4(1'b1, 4'(i));
        chk("t2_throughput_cycles", 32'(cyc - cyc0), 32'd32);
        drain4();

        // T4: fill the pipe, stall 5 cycles, then release
        r4 = 0;
        send4(1'b0, 4'b0011);
        send4(1'b1, 4'b0101);
        v4 = 1; m4 = 0; d4 = 4'hA;
        for (int n = 0; n < 5; n++) begin
            #1;
            chk("t4_in_ready_low", 32'(rdy4), 32'd0);
            chk("t4_out_valid", 32'(ov4), 32'd1);
            chk("t4_out_data_stable", 32'(od4), 32'b0010);
            tick();
        end
        r4 = 1;
        #1;
        chk("t4_in_ready_rise", 32'(rdy4), 32'd1);
        for (int n = 0; n < 10; n++) begin
            tick();
            if (acc4) break;
        end
        chk("t4_third_accept", 32'(acc4), 32'd1);
        drain4();

        // T3: wide stream in both modes with random downstream stalls
        rnd16 = 1;
        for (int i = 0; i < 1525; i++) send16(1'b1, 16'(i * 43));
        send16(1'b1, 16'hFFFF);
        for (int i = 0; i < 1525; i++) send16(1'b0, 16'(i * 43));
        send16(1'b0, 16'hFFFF);
        send16(1'b0, 16'h8000);
        drain16();
        rnd16 = 0; r16 = 1;

        // T5: asynchronous reset with two beats in flight
        send4(1'b0, 4'h6);
        send4(1'b0, 4'h7);
        v4 = 0;
        #2;
        resetn = 1'b0;
        #1;
        chk("t5_out_valid", 32'(ov4), 32'd0);
        chk("t5_out_data", 32'(od4), 32'd0);
        chk("t5_out_mode", 32'(om4), 32'd0);
        q4.delete(); q16.delete();
        pok4 = 0; pok16 = 0; hold16 = 0;
        @(negedge clk);
        resetn = 1'b1;
        for (int n = 0; n < 6; n++) begin
            chk("t5_no_stale_beat", 32'(ov4), 32'd0);
            tick();
        end

        // T6: Gray adjacency sequence
        do_reset();
        send4(1'b0, 4'b0000);
        send4(1'b0, 4'b0001);
        send4(1'b0, 4'b0011);
        send4(1'b0, 4'b0000);
        drain4();
        chk("t6_seq_err_history", 32'(serr_hist), SEQ_EN ? 32'b0001 : 32'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
